// File: rtl/serial_adder_pkg.sv
// rtl/serial_adder_pkg.sv - shared types and helpers for the digit-serial adder
package serial_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } sa_state_t;

  // Digit counter width; a single-digit adder still needs one counter bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/serial_adder_digit_adder.sv
// rtl/serial_adder_digit_adder.sv - combinational DIGIT-bit ripple-carry slice
module digit_adder #(
  parameter int DIGIT = 4
) (
  input  logic [DIGIT-1:0] x,
  input  logic [DIGIT-1:0] y,
  input  logic             ci,
  output logic [DIGIT-1:0] s,
  output logic             co
);

  logic [DIGIT:0] c;

  assign c[0] = ci;

  // One full-adder cell per bit, carry rippling upward.
  for (genvar i = 0; i < DIGIT; i++) begin : g_fa
    assign s[i]   = x[i] ^ y[i] ^ c[i];
    assign c[i+1] = (x[i] & y[i]) | (x[i] & c[i]) | (y[i] & c[i]);
  end

  assign co = c[DIGIT];

endmodule

// File: rtl/serial_adder.sv
// rtl/serial_adder.sv - digit-serial adder/subtractor with start/done handshake
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = cnt_width(N);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  if ((WIDTH % DIGIT) != 0 || DIGIT > WIDTH) begin : g_bad_params
    $error("serial_adder: WIDTH must be a non-zero multiple of DIGIT");
  end

  sa_state_t        state_q;
  logic [WIDTH-1:0] opa_q;
  logic [WIDTH-1:0] opb_q;
  logic             carry_q;
  logic [WIDTH-1:0] acc_q;
  logic [WIDTH-1:0] acc_d;
  logic [CW-1:0]    cnt_q;
  logic             a_msb_q;
  logic             b_msb_q;
  logic [WIDTH-1:0] sum_q;
  logic             cout_q;
  logic             ovf_q;

  logic [DIGIT-1:0] slice_s;
  logic             slice_co;

  digit_adder #(.DIGIT(DIGIT)) u_digit (
    .x  (opa_q[DIGIT-1:0]),
    .y  (opb_q[DIGIT-1:0]),
    .ci (carry_q),
    .s  (slice_s),
    .co (slice_co)
  );

  // Slice result enters at the top; after N digits the LSB digit has reached bit 0.
  if (N == 1) begin : g_acc_single
    assign acc_d = slice_s;
  end else begin : g_acc_shift
    assign acc_d = {slice_s, acc_q[WIDTH-1:DIGIT]};
  end

  // Control FSM plus operand/accumulator shift registers and result registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      opa_q   <= '0;
      opb_q   <= '0;
      carry_q <= 1'b0;
      acc_q   <= '0;
      cnt_q   <= '0;
      a_msb_q <= 1'b0;
      b_msb_q <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            // Subtraction is A + ~B + 1; cin then acts as a borrow-in.
            opa_q   <= a;
            opb_q   <= sub ? ~b : b;
            carry_q <= cin ^ sub;
            acc_q   <= '0;
            cnt_q   <= '0;
            a_msb_q <= a[WIDTH-1];
            b_msb_q <= b[WIDTH-1] ^ sub;
            state_q <= RUN;
          end
        end
        RUN: begin
          carry_q <= slice_co;
          opa_q   <= opa_q >> DIGIT;
          opb_q   <= opb_q >> DIGIT;
          acc_q   <= acc_d;
          cnt_q   <= cnt_q + CW'(1);
          if (cnt_q == LAST) begin
            sum_q   <= acc_d;
            cout_q  <= slice_co;
            ovf_q   <= (a_msb_q == b_msb_q) && (acc_d[WIDTH-1] != a_msb_q);
            state_q <= DONE;
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign ready = (state_q == IDLE);
  assign busy  = (state_q == RUN);
  assign done  = (state_q == DONE);
  assign sum   = sum_q;
  assign cout  = cout_q;
  assign ovf   = ovf_q;

endmodule

// File: tb/tb_serial_adder.sv
// tb/tb_serial_adder.sv - scoreboard bench for serial_adder (N=4 and N=1 instances)
module tb_serial_adder;

  localparam int W = 8;
  localparam int N = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic         start = 1'b0, cin = 1'b0, sub = 1'b0;
  logic [W-1:0] a = '0, b = '0;
  logic         ready, busy, done, cout, ovf;
  logic [W-1:0] sum;

  logic         start1 = 1'b0, cin1 = 1'b0, sub1 = 1'b0;
  logic [W-1:0] a1 = '0, b1 = '0;
  logic         ready1, busy1, done1, cout1, ovf1;
  logic [W-1:0] sum1;

  serial_adder #(.WIDTH(W), .DIGIT(2)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .cin(cin), .sub(sub),
    .ready(ready), .busy(busy), .done(done), .sum(sum), .cout(cout), .ovf(ovf)
  );

  serial_adder #(.WIDTH(W), .DIGIT(8)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .a(a1), .b(b1), .cin(cin1), .sub(sub1),
    .ready(ready1), .busy(busy1), .done(done1), .sum(sum1), .cout(cout1), .ovf(ovf1)
  );

  typedef struct {
    logic [W-1:0] s;
    logic         co;
    logic         ov;
    int           ec;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  exp_t e0, e1;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  bit mon_en = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      chk("onehot0", 32'($countones({ready, busy, done})), 32'd1);
      chk("onehot1", 32'($countones({ready1, busy1, done1})), 32'd1);
      if (done === 1'b1) begin
        if (q0.size() == 0) begin
          chk("spurious_done0", 32'(done), 32'd0);
        end else begin
          e0 = q0.pop_front();
          chk("sum0", 32'(sum), 32'(e0.s));
          chk("cout0", 32'(cout), 32'(e0.co));
          chk("ovf0", 32'(ovf), 32'(e0.ov));
          chk("latency0", 32'(cyc), 32'(e0.ec));
        end
      end
      if (done1 === 1'b1) begin
        if (q1.size() == 0) begin
          chk("spurious_done1", 32'(done1), 32'd0);
        end else begin
          e1 = q1.pop_front();
          chk("sum1", 32'(sum1), 32'(e1.s));
          chk("cout1", 32'(cout1), 32'(e1.co));
          chk("ovf1", 32'(ovf1), 32'(e1.ov));
          chk("latency1", 32'(cyc), 32'(e1.ec));
        end
      end
    end
  end

  // Start one operation on the N=4 instance; optionally expect its result.
  task automatic issue0(input logic [W-1:0] va, input logic [W-1:0] vb, input logic ci,
                        input logic sb, input logic [W-1:0] es, input logic eco,
                        input logic eov, input bit push);
    int t;
    t = 0;
    while (ready !== 1'b1 && t < 50) begin
      @(negedge clk);
      t++;
    end
    chk("ready_before_start0", 32'(ready), 32'd1);
    a = va; b = vb; cin = ci; sub = sb; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    if (push) q0.push_back('{es, eco, eov, cyc + N});
  endtask

  task automatic drain(input string tag);
    int t;
    t = 0;
    while ((q0.size() != 0 || q1.size() != 0) && t < 50) begin
      @(negedge clk);
      t++;
    end
    chk(tag, 32'(q0.size() + q1.size()), 32'd0);
    @(negedge clk);
  endtask

  task automatic op0(input logic [W-1:0] va, input logic [W-1:0] vb, input logic ci,
                     input logic sb, input logic [W-1:0] es, input logic eco, input logic eov);
    issue0(va, vb, ci, sb, es, eco, eov, 1'b1);
    drain("done_timeout0");
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_ready"}, 32'(ready), 32'd1);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_sum"}, 32'(sum), 32'h00);
    chk({tag, "_cout"}, 32'(cout), 32'd0);
    chk({tag, "_ovf"}, 32'(ovf), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] ra, rb, ob;
    logic         rc, rs;
    logic [W:0]   full;

    // Asynchronous reset, asserted mid-cycle
    @(negedge clk);
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    check_reset_outputs("reset");
    chk("reset_ready1", 32'(ready1), 32'd1);
    chk("reset_sum1", 32'(sum1), 32'h00);
    mon_en = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Directed adds and subtracts
    op0(8'h5A, 8'h3C, 1'b0, 1'b0, 8'h96, 1'b0, 1'b1);
    op0(8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    op0(8'h0F, 8'h00, 1'b1, 1'b0, 8'h10, 1'b0, 1'b0);
    op0(8'h10, 8'h20, 1'b0, 1'b1, 8'hF0, 1'b0, 1'b0);
    op0(8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1);

    // Start during RUN is ignored; result holds through IDLE
    issue0(8'h5A, 8'h3C, 1'b0, 1'b0, 8'h96, 1'b0, 1'b1, 1'b1);
    @(negedge clk);
    a = 8'h01; b = 8'h01; start = 1'b1;
    chk("busy_in_run", 32'(busy), 32'd1);
    @(negedge clk);
    chk("busy_in_run2", 32'(busy), 32'd1);
    chk("sum_stable_in_run", 32'(sum), 32'h7F);
    @(negedge clk);
    start = 1'b0;
    drain("done_timeout_hs");
    for (int i = 0; i < 3; i++) begin
      chk("hold_ready", 32'(ready), 32'd1);
      chk("hold_sum", 32'(sum), 32'h96);
      @(negedge clk);
    end

    // Reset in the second RUN cycle abandons the operation
    issue0(8'h33, 8'h44, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #2;
    chk("busy_before_rst", 32'(busy), 32'd1);
    rst = 1'b1;
    #1;
    check_reset_outputs("midrst");
    @(negedge clk);
    rst = 1'b0;
    repeat (N + 2) @(negedge clk);
    op0(8'h12, 8'h34, 1'b0, 1'b0, 8'h46, 1'b0, 1'b0);

    // Model-checked random operations
    for (int i = 0; i < 8; i++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      rc = 1'($urandom);
      rs = 1'($urandom);
      ob = rs ? ~rb : rb;
      full = {1'b0, ra} + {1'b0, ob} + {{W{1'b0}}, rc ^ rs};
      op0(ra, rb, rc, rs, full[W-1:0], full[W],
          (ra[W-1] == ob[W-1]) && (full[W-1] != ra[W-1]));
    end

    // Single-digit instance: done one cycle after the start edge
    a1 = 8'h5A; b1 = 8'h3C; cin1 = 1'b0; sub1 = 1'b0; start1 = 1'b1;
    @(posedge clk);
    #1;
    start1 = 1'b0;
    q1.push_back('{8'h96, 1'b0, 1'b1, cyc + 1});
    drain("done_timeout1");
    a1 = 8'h80; b1 = 8'h01; sub1 = 1'b1; start1 = 1'b1;
    @(posedge clk);
    #1;
    start1 = 1'b0;
    q1.push_back('{8'h7F, 1'b1, 1'b1, cyc + 1});
    drain("done_timeout1b");

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
